// File: rtl/clock_reset_sequencer.sv
// rtl/clock_reset_sequencer.sv - DCM supervision with lock qualification, retry and ordered domain reset release
// Runs on the free-running board clock so it keeps working while the DCM output is absent.
module clock_reset_sequencer #(
  parameter int DCM_RST_CYCLES = 4,
  parameter int LOCK_TIMEOUT   = 1000,
  parameter int LOCK_FILTER    = 16,
  parameter int RELEASE_GAP    = 8,
  parameter int NUM_DOMAINS    = 3,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   locked,
  input  logic [7:0]             status,
  input  logic                   restart,
  output logic                   dcm_rst,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic                   ready,
  output logic                   fault,
  output logic [3:0]             retry_count
);
  localparam int CW = $clog2(DCM_RST_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam int GW = $clog2(RELEASE_GAP + 1);

  typedef enum logic [2:0] {
    S_RESET_DCM, S_WAIT_LOCK, S_STABLE, S_RELEASE, S_RUN, S_FAULT
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [1:0]             r_lock_sync, r_stop_sync;
  logic [CW-1:0]          r_rst_cnt, w_rst_cnt_nxt;
  logic [TW-1:0]          r_timer, w_timer_nxt;
  logic [FW-1:0]          r_filter, w_filter_nxt;
  logic [GW-1:0]          r_gap, w_gap_nxt;
  logic                   w_dcm_rst_nxt, w_ready_nxt, w_fault_nxt;
  logic [NUM_DOMAINS-1:0] w_domain_reset_nxt, w_dr_shift;
  logic [3:0]             w_retry_nxt;
  logic                   w_locked_s, w_stop_s, w_loss, w_reseq, w_timeout;
  logic                   w_unused_status;

  assign w_locked_s      = r_lock_sync[1];
  assign w_stop_s        = r_stop_sync[1];
  assign w_loss          = ((r_state == S_RELEASE) || (r_state == S_RUN)) && (!w_locked_s || w_stop_s);
  assign w_reseq         = restart || w_loss;
  assign w_timeout       = (r_timer == TW'(LOCK_TIMEOUT));
  assign w_dr_shift      = domain_reset << 1;
  assign w_unused_status = &{status[7:2], status[0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_sync  <= '0;
      r_stop_sync  <= '0;
      r_state      <= S_RESET_DCM;
      r_rst_cnt    <= '0;
      r_timer      <= '0;
      r_filter     <= '0;
      r_gap        <= '0;
      dcm_rst      <= 1'b1;
      domain_reset <= '1;
      ready        <= 1'b0;
      fault        <= 1'b0;
      retry_count  <= '0;
    end else begin
      r_lock_sync  <= {r_lock_sync[0], locked};
      r_stop_sync  <= {r_stop_sync[0], status[1]};
      r_state      <= w_state_nxt;
      r_rst_cnt    <= w_rst_cnt_nxt;
      r_timer      <= w_timer_nxt;
      r_filter     <= w_filter_nxt;
      r_gap        <= w_gap_nxt;
      dcm_rst      <= w_dcm_rst_nxt;
      domain_reset <= w_domain_reset_nxt;
      ready        <= w_ready_nxt;
      fault        <= w_fault_nxt;
      retry_count  <= w_retry_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_rst_cnt_nxt      = r_rst_cnt;
    w_timer_nxt        = r_timer;
    w_filter_nxt       = r_filter;
    w_gap_nxt          = r_gap;
    w_dcm_rst_nxt      = dcm_rst;
    w_domain_reset_nxt = domain_reset;
    w_ready_nxt        = ready;
    w_fault_nxt        = fault;
    w_retry_nxt        = retry_count;

    // restart and loss share one path so a coincident timeout cannot start a second sequence
    if (w_reseq) begin
      w_state_nxt        = S_RESET_DCM;
      w_rst_cnt_nxt      = '0;
      w_timer_nxt        = '0;
      w_filter_nxt       = '0;
      w_gap_nxt          = '0;
      w_dcm_rst_nxt      = 1'b1;
      w_domain_reset_nxt = '1;
      w_ready_nxt        = 1'b0;
      w_fault_nxt        = 1'b0;
      w_retry_nxt        = '0;
    end else begin
      case (r_state)
        S_RESET_DCM: begin
          if (r_rst_cnt == CW'(DCM_RST_CYCLES - 1)) begin
            w_state_nxt   = S_WAIT_LOCK;
            w_rst_cnt_nxt = '0;
            w_timer_nxt   = '0;
            w_dcm_rst_nxt = 1'b0;
          end else begin
            w_rst_cnt_nxt = r_rst_cnt + CW'(1);
          end
        end
        S_WAIT_LOCK, S_STABLE: begin
          if (w_timeout) begin
            if (retry_count == 4'(MAX_RETRIES)) begin
              w_state_nxt = S_FAULT;
              w_fault_nxt = 1'b1;
            end else begin
              w_state_nxt   = S_RESET_DCM;
              w_retry_nxt   = retry_count + 4'd1;
              w_rst_cnt_nxt = '0;
              w_dcm_rst_nxt = 1'b1;
            end
          end else begin
            w_timer_nxt = r_timer + TW'(1);
            if (r_state == S_WAIT_LOCK) begin
              if (w_locked_s) begin
                w_state_nxt  = S_STABLE;
                w_filter_nxt = '0;
              end
            end else if (!w_locked_s) begin
              w_state_nxt  = S_WAIT_LOCK;
              w_filter_nxt = '0;
            end else if (r_filter == FW'(LOCK_FILTER - 1)) begin
              w_state_nxt = S_RELEASE;
              w_gap_nxt   = '0;
            end else begin
              w_filter_nxt = r_filter + FW'(1);
            end
          end
        end
        S_RELEASE: begin
          // domain_reset drains from bit 0 upward; all-zero marks the last release
          if (r_gap == GW'(RELEASE_GAP - 1)) begin
            w_gap_nxt          = '0;
            w_domain_reset_nxt = w_dr_shift;
            if (w_dr_shift == '0) begin
              w_state_nxt = S_RUN;
              w_ready_nxt = 1'b1;
            end
          end else begin
            w_gap_nxt = r_gap + GW'(1);
          end
        end
        S_RUN:   ;
        S_FAULT: ;
        default: w_state_nxt = S_RESET_DCM;
      endcase
    end
  end
endmodule

// File: tb/tb_clock_reset_sequencer.sv
// tb/tb_clock_reset_sequencer.sv - randomized bench for clock_reset_sequencer against an elapsed-time reference model
module tb_clock_reset_sequencer;
  localparam int DCM_RST = 4, TIMEOUT = 64, FILTER = 16, GAP = 8, ND = 3, MAXR = 3;
  localparam int M_RST = 0, M_WAIT = 1, M_REL = 2, M_RUN = 3, M_FAULT = 4;

  logic          clk = 1'b0;
  logic          reset_n, locked, restart;
  logic [7:0]    status;
  logic          dcm_rst, ready, fault;
  logic [ND-1:0] domain_reset;
  logic [3:0]    retry_count;

  int n_vec = 0;
  int n_bad = 0;

  // model: phase, edges spent in phase, consecutive synced-lock samples, retries
  int m_phase, m_n, m_run, m_retries;
  bit lq[$], sq[$];

  always #5 clk = ~clk;

  clock_reset_sequencer #(
    .DCM_RST_CYCLES(DCM_RST), .LOCK_TIMEOUT(TIMEOUT), .LOCK_FILTER(FILTER),
    .RELEASE_GAP(GAP), .NUM_DOMAINS(ND), .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .locked(locked), .status(status), .restart(restart),
    .dcm_rst(dcm_rst), .domain_reset(domain_reset), .ready(ready), .fault(fault),
    .retry_count(retry_count)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [ND-1:0] exp_dr();
    logic [ND-1:0] v;
    for (int i = 0; i < ND; i++)
      v[i] = (m_phase == M_REL) ? (m_n < GAP * (i + 1)) : (m_phase != M_RUN);
    return v;
  endfunction

  task automatic model_reset();
    m_phase = M_RST; m_n = 0; m_run = 0; m_retries = 0;
    lq.delete(); sq.delete();
    lq.push_back(1'b0); lq.push_back(1'b0);
    sq.push_back(1'b0); sq.push_back(1'b0);
  endtask

  task automatic model_edge();
    bit ls, ss;
    ls = lq.pop_front(); ss = sq.pop_front();
    lq.push_back(locked); sq.push_back(status[1]);
    if (restart) begin
      m_phase = M_RST; m_n = 0; m_retries = 0;
    end else begin
      case (m_phase)
        M_RST: begin
          m_n++;
          if (m_n == DCM_RST) begin m_phase = M_WAIT; m_n = 0; m_run = 0; end
        end
        M_WAIT: begin
          m_n++;
          m_run = ls ? m_run + 1 : 0;
          if (m_n == TIMEOUT + 1) begin
            if (m_retries == MAXR) m_phase = M_FAULT;
            else begin m_retries++; m_phase = M_RST; m_n = 0; end
          end else if (m_run == FILTER + 1) begin
            m_phase = M_REL; m_n = 0;
          end
        end
        M_REL, M_RUN: begin
          if (!ls || ss) begin
            m_phase = M_RST; m_n = 0; m_retries = 0;
          end else if (m_phase == M_REL) begin
            m_n++;
            if (m_n == GAP * ND) m_phase = M_RUN;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs();
    check("dcm_rst", dcm_rst, m_phase == M_RST);
    check("domain_reset", domain_reset, exp_dr());
    check("ready", ready, m_phase == M_RUN);
    check("fault", fault, m_phase == M_FAULT);
    check("retry_count", retry_count, m_retries);
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) model_edge(); else model_reset();
    #1;
    check_outputs();
    status = {6'($urandom), status[1], 1'($urandom)};
  endtask

  task automatic run_until_ready(input int limit);
    int c = 0;
    while (!ready && c < limit) begin step(); c++; end
    check("reach_run", ready, 1);
  endtask

  initial begin
    int   cnt, e0, e1, e2, hi, pulses;
    logic prev;
    reset_n = 1'b0; locked = 1'b0; restart = 1'b0; status = '0;
    model_reset();
    step(); step();
    check("reset_dcm_rst", dcm_rst, 1);
    check("reset_dr", domain_reset, 3'b111);

    // power-up, lock arrives 10 cycles after dcm_rst falls
    reset_n = 1'b1;
    cnt = 0;
    while (dcm_rst && cnt < 20) begin step(); cnt++; end
    check("dcm_rst_width", cnt, DCM_RST);
    repeat (10) step();
    locked = 1'b1;
    cnt = 0; e0 = 0; e1 = 0; e2 = 0;
    while (!ready && cnt < 100) begin
      step(); cnt++;
      if (domain_reset == 3'b110 && e0 == 0) e0 = cnt;
      if (domain_reset == 3'b100 && e1 == 0) e1 = cnt;
      if (domain_reset == 3'b000 && e2 == 0) e2 = cnt;
    end
    check("rel_bit0_edge", e0, 27);
    check("rel_bit1_edge", e1, 35);
    check("rel_bit2_edge", e2, 43);
    check("ready_edge", cnt, 43);
    repeat ($urandom_range(5, 20)) step();

    // lock drop in RUN
    locked = 1'b0;
    step(); step();
    check("loss_ready_hold", ready, 1);
    step();
    check("loss_dr", domain_reset, 3'b111);
    repeat ($urandom_range(3, 15)) step();
    locked = 1'b1;
    run_until_ready(200);
    repeat ($urandom_range(3, 10)) step();

    // CLKIN-stopped pulse in RUN
    status[1] = 1'b1;
    repeat (3) step();
    status[1] = 1'b0;
    check("stop_ready", ready, 0);
    run_until_ready(200);

    // short lock glitch must not release
    restart = 1'b1; locked = 1'b0;
    step();
    restart = 1'b0;
    cnt = 0;
    while (dcm_rst && cnt < 20) begin step(); cnt++; end
    repeat (3) step();
    locked = 1'b1; repeat (10) step();
    locked = 1'b0; repeat (4) step();
    locked = 1'b1;
    cnt = 0;
    while (domain_reset == 3'b111 && cnt < 100) begin step(); cnt++; end
    check("glitch_release_edge", cnt, 27);
    run_until_ready(200);

    // lock never arrives: retries then FAULT
    restart = 1'b1; locked = 1'b0;
    prev = dcm_rst; pulses = 0; cnt = 0;
    while (!fault && cnt < 600) begin
      step(); restart = 1'b0;
      if (dcm_rst && !prev) pulses++;
      prev = dcm_rst; cnt++;
    end
    check("fault_set", fault, 1);
    check("dcm_pulses", pulses, 4);
    check("fault_dr", domain_reset, 3'b111);
    repeat ($urandom_range(5, 20)) step();

    // restart out of FAULT
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("restart_fault_clr", fault, 0);
    check("restart_retry_clr", retry_count, 0);

    // restart coinciding with a timeout yields one pulse
    cnt = 0;
    while (!(m_phase == M_WAIT && m_n == TIMEOUT) && cnt < 200) begin step(); cnt++; end
    restart = 1'b1; hi = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      restart = 1'b0;
      hi += int'(dcm_rst);
    end
    check("single_pulse_width", hi, DCM_RST);
    check("restart_timeout_retry", retry_count, 0);

    // async reset in mid-release
    locked = 1'b1;
    cnt = 0;
    while (!(m_phase == M_REL && exp_dr() == 3'b100) && cnt < 200) begin step(); cnt++; end
    check("mid_release_dr", domain_reset, 3'b100);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check("async_dr", domain_reset, 3'b111);
    check("async_dcm_rst", dcm_rst, 1);
    check("async_ready", ready, 0);
    #1 reset_n = 1'b1;
    run_until_ready(200);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) locked = ~locked;
      status[1] = ($urandom_range(0, 99) == 0);
      restart   = ($urandom_range(0, 149) == 0);
      step();
    end
    restart = 1'b0; status[1] = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
